// File: rtl/tristate_bus_arbiter_if.sv
// tristate_bus_arbiter_if: request/grant signal bundle between channels and the arbiter
interface tristate_bus_arbiter_if #(
  parameter int NCH = 4,
  parameter int WIDTH = 8
);
  localparam int OW = NCH > 2 ? $clog2(NCH) : 1;
  logic [NCH-1:0] req;
  logic [NCH*WIDTH-1:0] data_in;
  logic [NCH-1:0] gnt;
  logic bus_oe;
  logic [OW-1:0] owner;
  logic busy;
  modport master (output req, data_in, input gnt, bus_oe, owner, busy);
  modport slave (input req, data_in, output gnt, bus_oe, owner, busy);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner of a shared tri-state bus; define TRI_BUS_TURNAROUND_EN for a high-Z TURN cycle on every ownership change
module tristate_bus_arbiter #(
  parameter int NCH = 4,
  parameter int WIDTH = 8,
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic rst_n,
  tristate_bus_arbiter_if.slave bi,
  inout wire [WIDTH-1:0] bus
);
  localparam int OW = NCH > 2 ? $clog2(NCH) : 1;
  localparam int HW = MAX_HOLD > 2 ? $clog2(MAX_HOLD) : 1;
`ifdef TRI_BUS_TURNAROUND_EN
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
`else
  typedef enum logic {IDLE, DRIVE} state_t;
`endif
  state_t state, state_nx;
  logic [OW-1:0] owner, owner_nx, ptr, ptr_nx, win, idx;
  logic [HW-1:0] hold, hold_nx;
  logic [NCH-1:0] cand;
  logic found, last, leave, oe;

  // round-robin search from ptr; the current owner is not a candidate while it drives
  always_comb begin
    cand = state == DRIVE ? bi.req & ~(NCH'(1) << owner) : bi.req;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = OW'((int'(ptr) + k) % NCH);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end

  // next state: hold or release the owner, hand over to the next winner or go idle
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx = ptr;
    hold_nx = hold;
    last = hold == HW'(MAX_HOLD - 1);
    leave = !bi.req[owner] || (last && found);
    if (state == DRIVE && !leave) hold_nx = last ? '0 : hold + 1'b1;
`ifdef TRI_BUS_TURNAROUND_EN
    else if (state == DRIVE) state_nx = TURN;
`endif
    else if (found) begin
      state_nx = DRIVE;
      owner_nx = win;
      ptr_nx = win == OW'(NCH - 1) ? '0 : win + 1'b1;
      hold_nx = '0;
    end
    else state_nx = IDLE;
  end

  // state registers; reset floats the bus at once since bus_oe decodes straight from state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      hold <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr <= ptr_nx;
      hold <= hold_nx;
    end
  end

  assign oe = state == DRIVE;
  assign bi.bus_oe = oe;
  assign bi.gnt = oe ? NCH'(1) << owner : '0;
  assign bi.owner = owner;
  assign bi.busy = state != IDLE;
  assign bus = oe ? bi.data_in[int'(owner)*WIDTH +: WIDTH] : 'z;
endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Parametrised N-channel shared-bus driver with round-robin ownership. Each channel requests the bus and the block grants exactly one owner at a time. It gates that owner's data onto a single tri-state bus and floats the bus (high-Z) whenever no one owns it. It extends the single-line tri-state buffer to multi-bit, multi-source buses, adding arbitration, a hold limit and an optional turnaround cycle.

## Interface
- NCH, 4 — number of requesting channels (2..16)
- WIDTH, 8 — bus width in bits
- MAX_HOLD, 4 — max consecutive beats one owner keeps the bus while others wait (≥1)

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NCH  per-channel bus request, level
- data_in  input  NCH*WIDTH  channel i data at [i*WIDTH +: WIDTH]
- gnt  output  NCH  one-hot grant (all-zero when bus free)
- bus  inout  WIDTH  shared bus; data_in of owner when bus_oe=1, else all 'z
- bus_oe  output  1  bus driven this cycle
- owner  output  max(1,$clog2(NCH))  index of current owner (valid when bus_oe=1)
- busy  output  1  state != IDLE

## Operation
- States: IDLE, DRIVE, TURN (TURN only with macro).
- Arbitration: round-robin from pointer ptr; search ptr, ptr+1, … NCH-1, 0, … ptr-1; first channel with req=1 wins. On each grant, ptr ← winner+1 (mod NCH).
- IDLE: gnt=0, bus_oe=0, bus='z. If |req → DRIVE with winner registered in owner/gnt.
- DRIVE: gnt one-hot at owner, bus_oe=1, bus = data_in[owner] (combinational from live data_in, gated by registered bus_oe). hold_cnt increments each beat.
- Leave DRIVE when (a) req[owner]=0, or (b) hold_cnt==MAX_HOLD-1 and any other channel requests.
- Sole requester at MAX_HOLD: keeps ownership, hold_cnt → 0.
- On leave, with macro: → TURN. Without macro: if any req, excluding the owner in case (b) → DRIVE with new winner; otherwise → IDLE.
- TURN: one cycle, gnt=0, bus_oe=0, bus='z. Then arbitrate exactly as IDLE.
- Owner dropping req and re-asserting it is a fresh request; it waits its round-robin turn.
- gnt never has more than one bit set; bus_oe==|gnt at all times.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, gnt=0, bus_oe=0, bus='z, owner=0, ptr=0, hold_cnt=0, busy=0. Assertion mid-DRIVE floats the bus immediately, without waiting for a clock edge.
- Request-to-grant latency: req sampled high at edge k → gnt/bus_oe high after edge k (one cycle), bus valid same cycle.
- Release: req[owner] low at edge k → gnt drops after edge k.
- Handover without macro: gnt switches one-hot to one-hot at one edge, with no idle cycle.
- Handover with macro: exactly one cycle of bus='z between owners.
- Max wait for any continuously requesting channel: (NCH-1)*(MAX_HOLD+T) cycles, T=1 with macro, else 0.

## Configuration
- TRI_BUS_TURNAROUND_EN defined: every ownership change (including DRIVE→IDLE) passes through TURN, giving a guaranteed high-Z cycle that prevents drive overlap on external buses.
- Undefined: TURN state is not compiled in; back-to-back handover, full bus utilisation.

## Test plan
- Reset: rst_n=0 with req=4'b1111 → gnt=0, bus_oe=0, bus=8'hzz. Release, then one edge → gnt=4'b0001, bus=data_in[0].
- Single channel: req=4'b0100, data_in[2]=8'hA5 for 10 cycles → gnt=4'b0100 throughout (no forced release), bus=8'hA5. Drop req → IDLE, bus='z next cycle.
- Fairness: req=4'b1111 held, MAX_HOLD=4 → owners 0,1,2,3,0 each for exactly 4 beats. With macro, 1 'z cycle between owners; without, none.
- Round-robin pointer: ch1 granted and released, then req=4'b0011 → ch... ptr=2, so search 2,3,0 → ch0 granted.
- Early release: owner ch3 drops req after 2 beats while req[1]=1 → ch1 gets the bus at next edge (macro off) or after 1 'z cycle (macro on).
- Async reset mid-DRIVE: rst_n falls between edges → bus='z and gnt=0 before the next clk edge; after release, arbitration restarts from ptr=0.
